cnt_sched: RTL and testbench

Two-requester scheduler for the shared 4-bit up-counter datapath. It arbitrates round-robin between requesters, latches the winner's run length and drives the counter's synchronous clear and enable. It runs the counter from 0 up to that length, then pulses a per-requester done flag. It sits beside the counter and is the only agent allowed to drive the counter's clear/enable.

---
 rtl/cnt_sched.sv | 88 ++++++++
 tb/tb_cnt_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cnt_sched.sv
// Round-robin scheduler for two requesters that share one up-counter.
// It owns the counter's clear and enable and pulses DONE when a run completes.
module cnt_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       REQ,
    input  logic [WIDTH-1:0] LEN0,
    input  logic [WIDTH-1:0] LEN1,
    input  logic [WIDTH-1:0] CNT,
    output logic [1:0]       GNT,
    output logic [1:0]       DONE,
    output logic             BUSY,
    output logic             CNT_CLR,
    output logic             CNT_EN
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             last_q, last_d;
    logic             win;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            len_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    // On a tie the requester that did not win last time gets the grant.
    assign win = (REQ == 2'b11) ? ~last_q : REQ[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (REQ != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    len_d   = win ? LEN1 : LEN0;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = (len_q != '0) ? StRun : StFin;
            end
            StRun: begin
                // The counter reaches len_q on the same edge that leaves RUN.
                if (CNT == len_q - WIDTH'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        GNT     = gnt_q;
        DONE    = (state_q == StFin) ? gnt_q : 2'b00;
        BUSY    = (state_q != StIdle);
        CNT_CLR = (state_q == StClear);
        CNT_EN  = (state_q == StRun);
    end

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched; models the external 4-bit counter and checks
// grant order, run lengths, DONE timing and asynchronous reset behaviour.
module tb_cnt_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] REQ;
    logic [3:0] LEN0;
    logic [3:0] LEN1;
    logic [3:0] cnt = 4'd0;
    logic [1:0] GNT;
    logic [1:0] DONE;
    logic       BUSY;
    logic       CNT_CLR;
    logic       CNT_EN;

    int n_checks = 0;
    int n_fail   = 0;

    cnt_sched #(
        .WIDTH(4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .LEN0   (LEN0),
        .LEN1   (LEN1),
        .CNT    (cnt),
        .GNT    (GNT),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .CNT_CLR(CNT_CLR),
        .CNT_EN (CNT_EN)
    );

    always #5 CLK = ~CLK;

    // Counter that the scheduler drives; it has no reset of its own.
    always @(posedge CLK) begin
        if (CNT_CLR) begin
            cnt <= 4'd0;
        end else if (CNT_EN) begin
            cnt <= cnt + 4'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Grant edge, then follow the run to DONE and the IDLE cycle after it.
    task automatic do_run(input logic [1:0] exp_gnt, input logic [3:0] exp_len,
                          input logic [1:0] req_run, input logic [3:0] len0_run);
        int en_cycles = 0;
        int cycles    = 0;
        bit seen_done = 1'b0;
        tick();
        check_eq("grant", GNT, exp_gnt);
        check_eq("busy_at_grant", BUSY, 1);
        check_eq("clr_at_grant", CNT_CLR, 1);
        check_eq("en_at_grant", CNT_EN, 0);
        check_eq("done_at_grant", DONE, 0);
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            cycles++;
            if (cycles == 1) begin
                REQ  = req_run;
                LEN0 = len0_run;
            end
            if (DONE != 2'b00) begin
                seen_done = 1'b1;
                check_eq("done_value", DONE, exp_gnt);
                check_eq("done_cnt", cnt, exp_len);
                check_eq("done_gnt", GNT, exp_gnt);
                check_eq("en_cycles", en_cycles, exp_len);
                check_eq("done_latency", cycles, exp_len + 1);
                check_eq("done_no_en", CNT_EN, 0);
            end else begin
                if (CNT_EN) en_cycles++;
                check_eq("clr_once", CNT_CLR, 0);
            end
        end
        if (!seen_done) check_eq("done_timeout", 0, 1);
        tick();
        check_eq("idle_gnt", GNT, 0);
        check_eq("idle_busy", BUSY, 0);
        check_eq("idle_done", DONE, 0);
    endtask

    initial begin
        bit hit3 = 1'b0;
        RST  = 1'b1;
        REQ  = 2'b00;
        LEN0 = 4'd0;
        LEN1 = 4'd0;
        tick();
        tick();
        check_eq("rst_gnt", GNT, 0);
        check_eq("rst_done", DONE, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_clr", CNT_CLR, 0);
        check_eq("rst_en", CNT_EN, 0);
        RST = 1'b0;

        // Single requester 0, length 5.
        REQ  = 2'b01;
        LEN0 = 4'd5;
        do_run(2'b01, 4'd5, 2'b00, 4'd5);

        // Requester 1 with zero length: CLEAR then FIN only.
        REQ  = 2'b10;
        LEN1 = 4'd0;
        do_run(2'b10, 4'd0, 2'b00, 4'd5);

        // Both held: strict alternation, one IDLE cycle between runs.
        REQ  = 2'b11;
        LEN0 = 4'd3;
        LEN1 = 4'd2;
        do_run(2'b01, 4'd3, 2'b11, 4'd3);
        do_run(2'b10, 4'd2, 2'b11, 4'd3);
        do_run(2'b01, 4'd3, 2'b11, 4'd3);
        do_run(2'b10, 4'd2, 2'b11, 4'd3);
        REQ = 2'b00;

        // Max length; LEN0 change and REQ drop mid-run must be ignored.
        REQ  = 2'b01;
        LEN0 = 4'd15;
        do_run(2'b01, 4'd15, 2'b00, 4'd2);

        // Asynchronous reset while CNT is 3 of an 8-long run.
        REQ  = 2'b01;
        LEN0 = 4'd8;
        tick();
        check_eq("r5_grant", GNT, 2'b01);
        REQ = 2'b00;
        for (int i = 0; i < 20 && !hit3; i++) begin
            tick();
            if (cnt == 4'd3) hit3 = 1'b1;
        end
        check_eq("r5_reach3", hit3, 1);
        #2;
        RST = 1'b1;
        #1;
        check_eq("arst_gnt", GNT, 0);
        check_eq("arst_done", DONE, 0);
        check_eq("arst_busy", BUSY, 0);
        check_eq("arst_clr", CNT_CLR, 0);
        check_eq("arst_en", CNT_EN, 0);
        REQ = 2'b11;
        tick();
        check_eq("arst_no_done", DONE, 0);
        check_eq("arst_cnt_kept", cnt, 3);
        RST = 1'b0;
        tick();
        check_eq("post_rst_tie", GNT, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
